signed_addsub_pipe: RTL and testbench

//  Parametrised, pipelined signed adder/subtractor with overflow detection, optional saturation
//  and a sticky overflow flag. Successor to the 8-bit ripple adder: arbitrary WIDTH, carry

---
 rtl/signed_addsub_pkg.sv | 22 ++
 rtl/addsub_chunk.sv | 18 +
 rtl/signed_addsub_pipe.sv | 180 ++++++++++++++++++
 tb/tb_signed_addsub_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_addsub_pkg.sv
// rtl/signed_addsub_pkg.sv - shared types and saturation constants for the signed add/sub pipeline
package signed_addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Widest result the saturation helpers can describe; callers slice to their own width.
   localparam int MAX_W = 64;

   // Largest positive two's complement value of width w: 0111..1
   function automatic logic [MAX_W-1:0] sat_max(input int w);
      return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
   endfunction

   // Most negative two's complement value of width w: 1000..0
   function automatic logic [MAX_W-1:0] sat_min(input int w);
      return MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - combinational CHUNK-bit ripple slice of the add/sub carry chain
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] s,
   output logic             c_out,
   output logic             c_msb
);

   assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};

   // Carry into the slice MSB recovered from the MSB sum bit; the last stage uses it for overflow.
   assign c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/signed_addsub_pipe.sv
// rtl/signed_addsub_pipe.sv - pipelined signed adder/subtractor with saturation and sticky overflow
module signed_addsub_pipe
   import signed_addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] input_a,
   input  logic [WIDTH-1:0] input_b,
   input  logic             Cin,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             Cout,
   output logic             overflow,
   output logic             ovf_sticky,
   input  logic             ovf_clear
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   localparam logic [MAX_W-1:0] SAT_MAX_W = sat_max(WIDTH);
   localparam logic [MAX_W-1:0] SAT_MIN_W = sat_min(WIDTH);
   localparam logic [WIDTH-1:0] SAT_MAX   = SAT_MAX_W[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SAT_MIN   = SAT_MIN_W[WIDTH-1:0];

   if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("signed_addsub_pipe: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   op_e              op;
   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

   // Per-stage inputs (from ports for stage 0, from the previous register otherwise)
   logic [WIDTH-1:0] a_in   [STAGES];
   logic [WIDTH-1:0] b_in   [STAGES];
   logic [WIDTH-1:0] s_in   [STAGES];
   logic [WIDTH-1:0] s_nx   [STAGES];
   logic             v_in   [STAGES];
   logic             c_in   [STAGES];
   logic             sat_in [STAGES];
   logic [CHUNK-1:0] s_ch   [STAGES];
   logic             co_ch  [STAGES];
   logic             cm_ch  [STAGES];

   // Inter-stage registers; the final stage registers straight into the output registers below.
   logic [WIDTH-1:0] a_q    [STAGES];
   logic [WIDTH-1:0] b_q    [STAGES];
   logic [WIDTH-1:0] s_q    [STAGES];
   logic             v_q    [STAGES];
   logic             c_q    [STAGES];
   logic             sat_q  [STAGES];

   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q;
   logic             ovf_q, ovf_d;
   logic             sticky_q, sticky_d;

   // The only stall point is the output; every register advances together when it is free.
   assign en       = !(out_valid_q && !out_ready);
   assign in_ready = !rst && en;

   // Subtraction folds into addition of the inverted operand and inverted borrow.
   assign op    = op_e'(sub);
   assign b_eff = (op == OP_SUB) ? ~input_b : input_b;
   assign c_eff = (op == OP_SUB) ? ~Cin : Cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_src
         assign a_in[k]   = input_a;
         assign b_in[k]   = b_eff;
         assign s_in[k]   = '0;
         assign v_in[k]   = in_valid && in_ready;
         assign c_in[k]   = c_eff;
         assign sat_in[k] = sat;
      end else begin : g_src
         assign a_in[k]   = a_q[k-1];
         assign b_in[k]   = b_q[k-1];
         assign s_in[k]   = s_q[k-1];
         assign v_in[k]   = v_q[k-1];
         assign c_in[k]   = c_q[k-1];
         assign sat_in[k] = sat_q[k-1];
      end

      addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a     (a_in[k][k*CHUNK +: CHUNK]),
         .b     (b_in[k][k*CHUNK +: CHUNK]),
         .c_in  (c_in[k]),
         .s     (s_ch[k]),
         .c_out (co_ch[k]),
         .c_msb (cm_ch[k])
      );

      // Bits above the current chunk are still zero in s_in, so OR merges the new slice.
      assign s_nx[k] = s_in[k] | (WIDTH'(s_ch[k]) << (k * CHUNK));

      if (k < LAST) begin : g_reg
         // Stage k register: partial sum, carry, skewed operands and sat mode travel together.
         always_ff @(posedge clk) begin
            if (rst) begin
               v_q[k]   <= 1'b0;
               a_q[k]   <= '0;
               b_q[k]   <= '0;
               s_q[k]   <= '0;
               c_q[k]   <= 1'b0;
               sat_q[k] <= 1'b0;
            end else if (en) begin
               v_q[k]   <= v_in[k];
               a_q[k]   <= a_in[k];
               b_q[k]   <= b_in[k];
               s_q[k]   <= s_nx[k];
               c_q[k]   <= co_ch[k];
               sat_q[k] <= sat_in[k];
            end
         end
      end
   end

   assign ovf_d = cm_ch[LAST] ^ co_ch[LAST];

   // Clamp on signed overflow; a set raw MSB means the true result overflowed positive.
   always_comb begin
      sum_d = s_nx[LAST];
      if (sat_in[LAST] && ovf_d) begin
         sum_d = s_nx[LAST][WIDTH-1] ? SAT_MAX : SAT_MIN;
      end
   end

   // Output register; Cout and overflow always report the unclamped arithmetic.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (en) begin
         out_valid_q <= v_in[LAST];
         sum_q       <= sum_d;
         cout_q      <= co_ch[LAST];
         ovf_q       <= ovf_d;
      end
   end

   // Sticky flag: an overflowing transfer beats a simultaneous clear.
   always_comb begin
      sticky_d = sticky_q;
      if (ovf_clear) begin
         sticky_d = 1'b0;
      end
      if (out_valid_q && out_ready && ovf_q) begin
         sticky_d = 1'b1;
      end
   end

   // Sticky register, independent of the stall enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign sum        = sum_q;
   assign Cout       = cout_q;
   assign overflow   = ovf_q;
   assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_signed_addsub_pipe.sv
// tb/tb_signed_addsub_pipe.sv - self-checking bench for signed_addsub_pipe (WIDTH=8, CHUNK=4)
module tb_signed_addsub_pipe;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic         sat;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] input_a = '0;
   logic [W-1:0] input_b = '0;
   logic         Cin = 1'b0;
   logic         sub = 1'b0;
   logic         sat = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         Cout;
   logic         overflow;
   logic         ovf_sticky;
   logic         ovf_clear = 1'b0;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_xfer = 0;
   exp_t sb[$];
   exp_t cur_exp;
   logic rand_rdy = 1'b0;

   logic         stall_prev = 1'b0;
   logic [W-1:0] hold_sum;
   logic         hold_cout;
   logic         hold_ovf;

   vec_t tbl[10];

   signed_addsub_pipe #(.WIDTH(W), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .input_a(input_a), .input_b(input_b), .Cin(Cin), .sub(sub), .sat(sat),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .Cout(Cout),
      .overflow(overflow), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mkv(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                input logic s, input logic st, input logic [7:0] r,
                                input logic co, input logic ov);
      vec_t v;
      v.a = a; v.b = b; v.cin = cin; v.sub = s; v.sat = st;
      v.sum = r; v.cout = co; v.ovf = ov;
      return v;
   endfunction

   // Reference from signed integer arithmetic; carry from the unsigned effective-operand sum.
   function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                  input logic s, input logic st);
      vec_t v;
      int r;
      logic [8:0] raw;
      if (s) r = int'($signed(a)) - int'($signed(b)) - int'(cin);
      else   r = int'($signed(a)) + int'($signed(b)) + int'(cin);
      raw = {1'b0, a} + {1'b0, (s ? ~b : b)} + {8'd0, (s ? ~cin : cin)};
      v.a = a; v.b = b; v.cin = cin; v.sub = s; v.sat = st;
      v.ovf  = (r > 127) || (r < -128);
      v.cout = raw[8];
      if (st && v.ovf) v.sum = (r > 127) ? 8'h7F : 8'h80;
      else             v.sum = r[7:0];
      return v;
   endfunction

   // Scoreboard: push on accepted input, pop and compare on output transfer, watch stalls.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check("in_ready_during_rst", 32'(in_ready), 0);
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_hold_valid", 32'(out_valid), 1);
            check("stall_hold_sum", 32'(sum), 32'(hold_sum));
            check("stall_hold_cout", 32'(Cout), 32'(hold_cout));
            check("stall_hold_ovf", 32'(overflow), 32'(hold_ovf));
         end
         if (out_valid && out_ready) begin
            n_xfer++;
            if (sb.size() == 0) begin
               check("unexpected_beat", 32'(out_valid), 0);
            end else begin
               e = sb.pop_front();
               check("beat_sum", 32'(sum), 32'(e.sum));
               check("beat_cout", 32'(Cout), 32'(e.cout));
               check("beat_ovf", 32'(overflow), 32'(e.ovf));
            end
         end
         stall_prev = out_valid && !out_ready;
         if (stall_prev) begin
            hold_sum  = sum;
            hold_cout = Cout;
            hold_ovf  = overflow;
            check("in_ready_stalled", 32'(in_ready), 0);
         end
         if (in_valid && in_ready) sb.push_back(cur_exp);
      end
   end

   // Random output back-pressure, only while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input vec_t v);
      int guard;
      input_a = v.a; input_b = v.b; Cin = v.cin; sub = v.sub; sat = v.sat;
      cur_exp.sum = v.sum; cur_exp.cout = v.cout; cur_exp.ovf = v.ovf;
      in_valid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      check("send_accept", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      check("drain_empty", 32'(sb.size()), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic pat [6];
      int   x0;
      int   guard;

      tbl[0] = mkv(8'h50, 8'h30, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      tbl[1] = mkv(8'h50, 8'h30, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
      tbl[2] = mkv(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      tbl[3] = mkv(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
      tbl[4] = mkv(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
      tbl[5] = mkv(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      tbl[6] = mkv(8'h05, 8'h03, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
      tbl[7] = mkv(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
      tbl[8] = mkv(8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
      tbl[9] = mkv(8'h7F, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
      pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_sum", 32'(sum), 0);
      check("rst_cout", 32'(Cout), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_sticky", 32'(ovf_sticky), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // First overflowing beat alone, then sticky must be set
      send(tbl[0]);
      drain();
      check("sticky_after_ovf", 32'(ovf_sticky), 1);

      // Remaining vectors back to back
      for (int i = 1; i < 10; i++) send(tbl[i]);
      drain();

      // Reset with two beats in flight: nothing may emerge afterwards
      check("sticky_before_rst", 32'(ovf_sticky), 1);
      out_ready = 1'b0;
      send(tbl[0]);
      send(tbl[1]);
      rst = 1'b1;
      sb.delete();
      x0 = n_xfer;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid), 0);
      check("post_rst_sticky", 32'(ovf_sticky), 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("post_rst_no_beats", 32'(n_xfer - x0), 0);

      // Four back-to-back beats against out_ready pattern 1,0,0,1,1,1
      x0 = n_xfer;
      fork
         begin
            for (int i = 0; i < 4; i++) send(tbl[i + 2]);
         end
         begin
            for (int c = 0; c < 8; c++) begin
               if (c < 2) out_ready = 1'b1;
               else       out_ready = pat[c - 2];
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("burst_count", 32'(n_xfer - x0), 4);

      // Clear coinciding with an overflowing transfer: set wins, then clear next cycle
      ovf_clear = 1'b1;
      @(posedge clk);
      #1;
      ovf_clear = 1'b0;
      @(negedge clk);
      check("sticky_cleared", 32'(ovf_sticky), 0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(tbl[0]);
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 20) begin
         guard++;
         @(negedge clk);
      end
      check("ovf_beat_arrives", 32'(out_valid), 1);
      check("sticky_held_in_stall", 32'(ovf_sticky), 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      ovf_clear = 1'b1;
      @(posedge clk);
      #1;
      ovf_clear = 1'b0;
      @(negedge clk);
      check("sticky_set_wins", 32'(ovf_sticky), 1);
      @(posedge clk);
      #1;
      ovf_clear = 1'b1;
      @(posedge clk);
      #1;
      ovf_clear = 1'b0;
      @(negedge clk);
      check("sticky_clear_next", 32'(ovf_sticky), 0);
      @(posedge clk);
      #1;

      // Random operands under random back-pressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send(model(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
      end
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
